// File: rtl/sonar_ping_sequencer.sv
// Sonar ping sequencer: TX stream -> DAC, guard blank, ADC -> RX stream.
// Define SONAR_SEQ_TIMESTAMP_EN to prefix each RX burst with a header beat.
module sonar_ping_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int PER_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic                  cont_en,
  input  logic                  sample_tick,
  input  logic [LEN_WIDTH-1:0]  cfg_tx_len,
  input  logic [LEN_WIDTH-1:0]  cfg_guard_len,
  input  logic [LEN_WIDTH-1:0]  cfg_rx_len,
  input  logic [PER_WIDTH-1:0]  cfg_period,
  input  logic                  S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] dac_data,
  output logic                  dac_en,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  input  logic                  M_AXIS_TREADY,
  output logic                  busy,
  output logic [15:0]           ping_cnt,
  output logic                  err_underrun,
  output logic                  err_overflow,
  input  logic                  err_clr
);

`ifdef SONAR_SEQ_TIMESTAMP_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TX    = 3'd1;
  localparam logic [2:0] S_GUARD = 3'd2;
  localparam logic [2:0] S_RX    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]            state;
  logic [LEN_WIDTH-1:0]  tx_len_q;
  logic [LEN_WIDTH-1:0]  guard_len_q;
  logic [LEN_WIDTH-1:0]  rx_len_q;
  logic [PER_WIDTH-1:0]  period_q;
  logic [LEN_WIDTH-1:0]  phase_cnt;
  logic [PER_WIDTH-1:0]  per_cnt;
  logic [DATA_WIDTH-1:0] dac_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic [15:0]           ping_q;
  logic                  und_q;
  logic                  ovf_q;

  logic                  st_idle;
  logic                  st_tx;
  logic                  st_guard;
  logic                  st_rx;
  logic                  st_wait;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic                  phase_done;
  logic                  tick_take;
  logic                  tx_beat;
  logic                  m_accept;
  logic                  rx_tick;
  logic                  rx_drop;
  logic                  rx_exit;
  logic                  per_done;
  logic                  arm;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign st_idle  = (state == S_IDLE);
  assign st_tx    = (state == S_TX);
  assign st_guard = (state == S_GUARD);
  assign st_rx    = (state == S_RX);
  assign st_wait  = (state == S_WAIT);

  always_comb begin
    cur_len = '0;
    unique case (1'b1)
      st_tx:    cur_len = tx_len_q;
      st_guard: cur_len = guard_len_q;
      st_rx:    cur_len = rx_len_q;
      default:  cur_len = '0;
    endcase
  end

  assign phase_done = (phase_cnt == cur_len);
  assign tick_take  = st_tx & sample_tick & ~phase_done;
  assign tx_beat    = tick_take & S_AXIS_TVALID;
  assign m_accept   = m_valid_q & M_AXIS_TREADY;
  assign rx_tick    = st_rx & sample_tick & ~phase_done;
  // A beat that is being accepted this cycle frees the slot for a new sample.
  assign rx_drop    = rx_tick & m_valid_q & ~M_AXIS_TREADY;
  assign rx_exit    = st_rx & phase_done &
                      (~m_valid_q | M_AXIS_TREADY);
  assign per_done   = ({1'b0, per_cnt} + (PER_WIDTH+1)'(1))
                      >= {1'b0, period_q};
  assign arm        = (st_idle & start) |
                      (st_wait & cont_en & per_done);
  assign hdr_word   = DATA_WIDTH'({16'hA5A5, ping_q});

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= S_IDLE;
      tx_len_q    <= '0;
      guard_len_q <= '0;
      rx_len_q    <= '0;
      period_q    <= '0;
      phase_cnt   <= '0;
      per_cnt     <= '0;
      dac_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      ping_q      <= '0;
      und_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // Saturate so an overlong ping still sees per_done.
      if (per_cnt != '1)
        per_cnt <= per_cnt + PER_WIDTH'(1);
      if (m_accept)
        m_valid_q <= 1'b0;
      if (err_clr) begin
        und_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        if (tick_take & ~S_AXIS_TVALID)
          und_q <= 1'b1;
        if (rx_drop)
          ovf_q <= 1'b1;
      end
      if (arm) begin
        tx_len_q    <= cfg_tx_len;
        guard_len_q <= cfg_guard_len;
        rx_len_q    <= cfg_rx_len;
        period_q    <= cfg_period;
        phase_cnt   <= '0;
        per_cnt     <= '0;
        state       <= S_TX;
      end else begin
        unique case (1'b1)
          st_tx: begin
            if (phase_done) begin
              state     <= S_GUARD;
              phase_cnt <= '0;
              dac_q     <= '0;
            end else if (tick_take) begin
              phase_cnt <= phase_cnt + LEN_WIDTH'(1);
              dac_q     <= S_AXIS_TVALID ? S_AXIS_TDATA : '0;
            end
          end
          st_guard: begin
            if (phase_done) begin
              state     <= S_RX;
              phase_cnt <= '0;
              if (HDR_EN) begin
                m_valid_q <= 1'b1;
                m_data_q  <= hdr_word;
              end
            end else if (sample_tick) begin
              phase_cnt <= phase_cnt + LEN_WIDTH'(1);
            end
          end
          st_rx: begin
            if (rx_exit) begin
              state  <= S_WAIT;
              ping_q <= ping_q + 16'd1;
            end else if (rx_tick) begin
              phase_cnt <= phase_cnt + LEN_WIDTH'(1);
              if (!rx_drop) begin
                m_valid_q <= 1'b1;
                m_data_q  <= adc_data;
              end
            end
          end
          st_wait: begin
            if (!cont_en)
              state <= S_IDLE;
          end
          default: begin
            if (!st_idle)
              state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign S_AXIS_TREADY = tx_beat & ~ARESET;
  assign dac_data      = dac_q;
  assign dac_en        = st_tx;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign busy          = ~st_idle;
  assign ping_cnt      = ping_q;
  assign err_underrun  = und_q;
  assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Directed bench for sonar_ping_sequencer.
// Honours SONAR_SEQ_TIMESTAMP_EN for the header-beat expectations.
module tb_sonar_ping_sequencer;

`ifdef SONAR_SEQ_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        cont_en = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] cfg_tx_len = '0;
  logic [15:0] cfg_guard_len = '0;
  logic [15:0] cfg_rx_len = '0;
  logic [31:0] cfg_period = '0;
  logic        S_AXIS_TVALID = 1'b0;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TREADY;
  logic [31:0] dac_data;
  logic        dac_en;
  logic [31:0] adc_data = '0;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TREADY = 1'b1;
  logic        busy;
  logic [15:0] ping_cnt;
  logic        err_underrun;
  logic        err_overflow;
  logic        err_clr = 1'b0;

  sonar_ping_sequencer #(
    .DATA_WIDTH(32), .LEN_WIDTH(16), .PER_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .cont_en(cont_en), .sample_tick(sample_tick),
    .cfg_tx_len(cfg_tx_len), .cfg_guard_len(cfg_guard_len),
    .cfg_rx_len(cfg_rx_len), .cfg_period(cfg_period),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .dac_data(dac_data), .dac_en(dac_en), .adc_data(adc_data),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .busy(busy), .ping_cnt(ping_cnt),
    .err_underrun(err_underrun), .err_overflow(err_overflow),
    .err_clr(err_clr)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  int cyc = 0, tick_ph = 0, tick_id = 0;
  int stall_id = -1, hold_until = 0;
  logic [31:0] fifo [0:255];
  int rd_idx = 0, fifo_lim = 0;
  int tr_cnt = 0;
  int tr_cyc [0:255];
  int m_cnt = 0;
  logic [31:0] m_log [0:255];
  int dac_n = 0;
  logic [31:0] dac_log [0:255];
  int rise_n = 0;
  int rise_cyc [0:255];
  bit dac_pend = 0, en_prev = 0;

  // Environment: drives at +1 after posedge, samples at +8.
  initial begin
    forever begin
      @(posedge ACLK); #1;
      cyc++;
      if (tick_ph == 9) begin
        tick_ph = 0;
        tick_id++;
        sample_tick = 1'b1;
        adc_data = 32'hAD000000 + 32'(tick_id);
        if (tick_id == stall_id) hold_until = cyc + 25;
      end else begin
        tick_ph++;
        sample_tick = 1'b0;
      end
      M_AXIS_TREADY = (cyc >= hold_until);
      S_AXIS_TVALID = (rd_idx < fifo_lim);
      S_AXIS_TDATA = fifo[rd_idx % 256];
      #7;
      if (S_AXIS_TREADY && S_AXIS_TVALID) begin
        tr_cyc[tr_cnt % 256] = cyc;
        tr_cnt++;
        rd_idx++;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        m_log[m_cnt % 256] = M_AXIS_TDATA;
        m_cnt++;
      end
      if (dac_pend) begin
        dac_log[dac_n % 256] = dac_data;
        dac_n++;
      end
      dac_pend = sample_tick && dac_en;
      if (dac_en && !en_prev) begin
        rise_cyc[rise_n % 256] = cyc;
        rise_n++;
      end
      en_prev = dac_en;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #2;
    end
  endtask

  task automatic load_fifo(input int n);
    for (int i = 0; i < n; i++)
      fifo[(rd_idx + i) % 256] = 32'(i + 1);
    fifo_lim = rd_idx + n;
  endtask

  task automatic set_cfg(input int tx, input int gd, input int rx);
    cfg_tx_len = 16'(tx);
    cfg_guard_len = 16'(gd);
    cfg_rx_len = 16'(rx);
    cfg_period = 32'd200;
  endtask

  // Start aligned to a tick cycle so tick ids after start are fixed.
  task automatic start_ping(output int id0, output bit ok);
    ok = 0;
    id0 = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (sample_tick) begin
        ok = 1;
        break;
      end
    end
    start = 1'b1;
    id0 = tick_id;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      step(1);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    step(3);
    checks++; if (S_AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready got %0b exp 0", S_AXIS_TREADY); end
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL rst_dac got %0h exp 0", dac_data); end
    checks++; if (dac_en !== 1'b0) begin errors++; $display("FAIL rst_dac_en got %0b exp 0", dac_en); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %0b exp 0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== 32'h0) begin errors++; $display("FAIL rst_mdata got %0h exp 0", M_AXIS_TDATA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (ping_cnt !== 16'h0) begin errors++; $display("FAIL rst_ping got %0h exp 0", ping_cnt); end
    checks++; if ({err_underrun, err_overflow} !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", {err_underrun, err_overflow}); end
    ARESET = 1'b0;
    step(2);
  endtask

  task automatic test_single;
    int id0, tb0, mb, db;
    bit ok;
    load_fifo(4);
    set_cfg(4, 2, 3);
    cont_en = 1'b0;
    tb0 = tr_cnt; mb = m_cnt; db = dac_n;
    start_ping(id0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_start got timeout exp tick"); end
    step(3);
    cfg_tx_len = 16'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy exp idle"); end
    checks++; if (tr_cnt - tb0 != 4) begin errors++; $display("FAIL single_tready got %0d exp 4", tr_cnt - tb0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_log[(db + i) % 256] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL single_dac%0d got %0h exp %0h", i, dac_log[(db + i) % 256], i + 1);
      end
    end
    checks++; if (m_cnt - mb != 3 + HDR) begin errors++; $display("FAIL single_beats got %0d exp %0d", m_cnt - mb, 3 + HDR); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (m_log[(mb + HDR + j) % 256] !== 32'hAD000000 + 32'(id0 + 7 + j)) begin
        errors++;
        $display("FAIL single_rx%0d got %0h exp %0h", j, m_log[(mb + HDR + j) % 256], 32'hAD000000 + 32'(id0 + 7 + j));
      end
    end
    if (HDR == 1) begin
      checks++; if (m_log[mb % 256] !== 32'hA5A50000) begin errors++; $display("FAIL single_hdr got %0h exp a5a50000", m_log[mb % 256]); end
    end
    checks++; if (ping_cnt !== 16'd1) begin errors++; $display("FAIL single_ping got %0d exp 1", ping_cnt); end
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL single_dac_idle got %0h exp 0", dac_data); end
    checks++; if ({err_underrun, err_overflow} !== 2'b00) begin errors++; $display("FAIL single_err got %b exp 00", {err_underrun, err_overflow}); end
  endtask

  task automatic test_back_to_back;
    int id0, tb0, mb, rb, pc;
    bit ok;
    load_fifo(8);
    set_cfg(4, 2, 3);
    cont_en = 1'b1;
    tb0 = tr_cnt; mb = m_cnt; rb = rise_n; pc = int'(ping_cnt);
    start_ping(id0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_start got timeout exp tick"); end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (rise_n >= rb + 2) begin
        ok = 1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_rearm got %0d rises exp 2", rise_n - rb); end
    cont_en = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got busy exp idle"); end
    checks++; if (rise_cyc[(rb + 1) % 256] - rise_cyc[rb % 256] != 200) begin errors++; $display("FAIL b2b_tx_gap got %0d exp 200", rise_cyc[(rb + 1) % 256] - rise_cyc[rb % 256]); end
    checks++; if (tr_cnt - tb0 != 8) begin errors++; $display("FAIL b2b_tready got %0d exp 8", tr_cnt - tb0); end
    checks++; if (tr_cyc[(tb0 + 4) % 256] - tr_cyc[tb0 % 256] != 200) begin errors++; $display("FAIL b2b_tready_gap got %0d exp 200", tr_cyc[(tb0 + 4) % 256] - tr_cyc[tb0 % 256]); end
    checks++; if (ping_cnt !== 16'(pc + 2)) begin errors++; $display("FAIL b2b_ping got %0d exp %0d", ping_cnt, pc + 2); end
    checks++; if (m_cnt - mb != 6 + 2 * HDR) begin errors++; $display("FAIL b2b_beats got %0d exp %0d", m_cnt - mb, 6 + 2 * HDR); end
    if (HDR == 1) begin
      checks++; if (m_log[mb % 256] !== 32'hA5A50001) begin errors++; $display("FAIL b2b_hdr1 got %0h exp a5a50001", m_log[mb % 256]); end
      checks++; if (m_log[(mb + 4) % 256] !== 32'hA5A50002) begin errors++; $display("FAIL b2b_hdr2 got %0h exp a5a50002", m_log[(mb + 4) % 256]); end
    end
  endtask

  task automatic test_underrun;
    int id0, tb0, db, pc;
    bit ok;
    logic [31:0] exp_dac [0:3];
    exp_dac[0] = 32'd1; exp_dac[1] = 32'd2;
    exp_dac[2] = 32'd0; exp_dac[3] = 32'd0;
    load_fifo(2);
    set_cfg(4, 2, 3);
    tb0 = tr_cnt; db = dac_n; pc = int'(ping_cnt);
    start_ping(id0, ok);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL und_idle got busy exp idle"); end
    checks++; if (tr_cnt - tb0 != 2) begin errors++; $display("FAIL und_tready got %0d exp 2", tr_cnt - tb0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_log[(db + i) % 256] !== exp_dac[i]) begin
        errors++;
        $display("FAIL und_dac%0d got %0h exp %0h", i, dac_log[(db + i) % 256], exp_dac[i]);
      end
    end
    checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL und_flag got %0b exp 1", err_underrun); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL und_ovf got %0b exp 0", err_overflow); end
    checks++; if (ping_cnt !== 16'(pc + 1)) begin errors++; $display("FAIL und_ping got %0d exp %0d", ping_cnt, pc + 1); end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL und_clr got %0b exp 0", err_underrun); end
  endtask

  task automatic test_overflow;
    int id0, mb, pc;
    bit ok;
    load_fifo(4);
    set_cfg(4, 2, 3);
    mb = m_cnt; pc = int'(ping_cnt);
    start_ping(id0, ok);
    stall_id = id0 + 7;
    wait_idle(300, ok);
    stall_id = -1;
    checks++; if (!ok) begin errors++; $display("FAIL ovf_idle got busy exp idle"); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", err_overflow); end
    checks++; if (m_cnt - mb != 1 + HDR) begin errors++; $display("FAIL ovf_beats got %0d exp %0d", m_cnt - mb, 1 + HDR); end
    checks++; if (m_log[(mb + HDR) % 256] !== 32'hAD000000 + 32'(id0 + 7)) begin errors++; $display("FAIL ovf_data got %0h exp %0h", m_log[(mb + HDR) % 256], 32'hAD000000 + 32'(id0 + 7)); end
    checks++; if (ping_cnt !== 16'(pc + 1)) begin errors++; $display("FAIL ovf_ping got %0d exp %0d", ping_cnt, pc + 1); end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", err_overflow); end
  endtask

  task automatic test_zero_len;
    int id0, tb0, mb;
    bit ok;
    fifo_lim = rd_idx;
    set_cfg(0, 0, 2);
    tb0 = tr_cnt; mb = m_cnt;
    start_ping(id0, ok);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_idle got busy exp idle"); end
    checks++; if (tr_cnt != tb0) begin errors++; $display("FAIL zero_tready got %0d exp 0", tr_cnt - tb0); end
    checks++; if (m_cnt - mb != 2 + HDR) begin errors++; $display("FAIL zero_beats got %0d exp %0d", m_cnt - mb, 2 + HDR); end
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (m_log[(mb + HDR + j) % 256] !== 32'hAD000000 + 32'(id0 + 1 + j)) begin
        errors++;
        $display("FAIL zero_rx%0d got %0h exp %0h", j, m_log[(mb + HDR + j) % 256], 32'hAD000000 + 32'(id0 + 1 + j));
      end
    end
    checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL zero_und got %0b exp 0", err_underrun); end
  endtask

  task automatic test_reset_mid;
    int id0, tb0, mb, db;
    bit ok;
    load_fifo(4);
    set_cfg(4, 2, 3);
    tb0 = tr_cnt;
    start_ping(id0, ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (tr_cnt >= tb0 + 2) begin
        ok = 1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_tx got %0d beats exp 2", tr_cnt - tb0); end
    ARESET = 1'b1;
    step(1);
    checks++; if ({S_AXIS_TREADY, dac_en, M_AXIS_TVALID, busy} !== 4'b0000) begin errors++; $display("FAIL mid_ctrl got %b exp 0000", {S_AXIS_TREADY, dac_en, M_AXIS_TVALID, busy}); end
    checks++; if (dac_data !== 32'h0) begin errors++; $display("FAIL mid_dac got %0h exp 0", dac_data); end
    checks++; if (ping_cnt !== 16'h0) begin errors++; $display("FAIL mid_ping got %0d exp 0", ping_cnt); end
    ARESET = 1'b0;
    step(50);
    checks++; if (tr_cnt != tb0 + 2) begin errors++; $display("FAIL mid_quiet got %0d exp %0d", tr_cnt, tb0 + 2); end
    load_fifo(4);
    mb = m_cnt; db = dac_n;
    start_ping(id0, ok);
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_idle got busy exp idle"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dac_log[(db + i) % 256] !== 32'(i + 1)) begin
        errors++;
        $display("FAIL mid_dac%0d got %0h exp %0h", i, dac_log[(db + i) % 256], i + 1);
      end
    end
    checks++; if (m_cnt - mb != 3 + HDR) begin errors++; $display("FAIL mid_beats got %0d exp %0d", m_cnt - mb, 3 + HDR); end
    if (HDR == 1) begin
      checks++; if (m_log[mb % 256] !== 32'hA5A50000) begin errors++; $display("FAIL mid_hdr got %0h exp a5a50000", m_log[mb % 256]); end
    end
    checks++; if (ping_cnt !== 16'd1) begin errors++; $display("FAIL mid_ping_after got %0d exp 1", ping_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
